mii_rx_deframer: RTL and testbench

//  Receive-side MII deframer feeding the mii2mii forwarding core. Samples the

---
 rtl/mii_rx_deframer.sv | 178 +++++++++++++++++
 tb/tb_mii_rx_deframer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: checks preamble/SFD, packs nibbles into bytes
// (low nibble first) and reports per-frame end status and good/bad counts.
module mii_rx_deframer #(
    parameter int MIN_PRE = 7,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        SW0,
    input  logic        miiI_en,
    input  logic [3:0]  miiI_d,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic [10:0] frame_len,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_err
);

    typedef enum logic [2:0] {IDLE, PRE, LO, HI, DROP} state_t;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [10:0] len_q, len_d;
    logic        first_q, first_d;
    logic [3:0]  lo_q, lo_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_sof_q, rx_sof_d;
    logic        rx_eof_q, rx_eof_d;
    logic        rx_err_q, rx_err_d;
    logic [10:0] frame_len_q, frame_len_d;
    logic [15:0] frames_ok_q, frames_ok_d;
    logic [15:0] frames_err_q, frames_err_d;
    logic        bump_ok_s, bump_err_s;
    logic        len_bad_s;

    assign len_bad_s = (len_q < 11'(MIN_LEN)) || (len_q > 11'(MAX_LEN));

    // Next-state, datapath and status computation.
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q | ~miiI_en;
        pre_cnt_d    = pre_cnt_q;
        len_d        = len_q;
        first_d      = first_q;
        lo_d         = lo_q;
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = 1'b0;
        rx_sof_d     = 1'b0;
        rx_eof_d     = 1'b0;
        rx_err_d     = 1'b0;
        frame_len_d  = frame_len_q;
        bump_ok_s    = 1'b0;
        bump_err_s   = 1'b0;

        case (state_q)
            IDLE: begin
                // armed_q keeps the tail of a frame cut by reset from being parsed
                if (armed_q && miiI_en) begin
                    if (miiI_d == 4'h5) begin
                        state_d   = PRE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d    = DROP;
                        bump_err_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PRE: begin
                if (!miiI_en) begin
                    state_d = IDLE;
                end else if (miiI_d == 4'h5) begin
                    pre_cnt_d = (pre_cnt_q == 4'hF) ? pre_cnt_q : pre_cnt_q + 4'd1;
                end else if ((miiI_d == 4'hD) && (pre_cnt_q >= 4'(MIN_PRE))) begin
                    state_d = LO;
                    len_d   = 11'd0;
                    first_d = 1'b1;
                end else begin
                    state_d    = DROP;
                    bump_err_s = 1'b1;
                end
            end
            LO: begin
                if (miiI_en) begin
                    lo_d    = miiI_d;
                    state_d = HI;
                end else begin
                    state_d     = IDLE;
                    rx_eof_d    = 1'b1;
                    rx_err_d    = len_bad_s;
                    frame_len_d = len_q;
                    bump_ok_s   = ~len_bad_s;
                    bump_err_s  = len_bad_s;
                end
            end
            HI: begin
                if (miiI_en) begin
                    rx_byte_d  = {miiI_d, lo_q};
                    rx_valid_d = 1'b1;
                    rx_sof_d   = first_q;
                    first_d    = 1'b0;
                    len_d      = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
                    state_d    = LO;
                end else begin
                    state_d     = IDLE;
                    rx_eof_d    = 1'b1;
                    rx_err_d    = 1'b1;
                    frame_len_d = len_q;
                    bump_err_s  = 1'b1;
                end
            end
            DROP: begin
                if (!miiI_en) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        frames_ok_d  = bump_ok_s  ? frames_ok_q  + 16'd1 : frames_ok_q;
        frames_err_d = bump_err_s ? frames_err_q + 16'd1 : frames_err_q;
    end

    // State and registered outputs; SW0 low clears everything immediately.
    always_ff @(posedge clk or negedge SW0) begin
        if (!SW0) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            pre_cnt_q    <= 4'd0;
            len_q        <= 11'd0;
            first_q      <= 1'b0;
            lo_q         <= 4'd0;
            rx_byte_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_sof_q     <= 1'b0;
            rx_eof_q     <= 1'b0;
            rx_err_q     <= 1'b0;
            frame_len_q  <= 11'd0;
            frames_ok_q  <= 16'd0;
            frames_err_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            pre_cnt_q    <= pre_cnt_d;
            len_q        <= len_d;
            first_q      <= first_d;
            lo_q         <= lo_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            rx_sof_q     <= rx_sof_d;
            rx_eof_q     <= rx_eof_d;
            rx_err_q     <= rx_err_d;
            frame_len_q  <= frame_len_d;
            frames_ok_q  <= frames_ok_d;
            frames_err_q <= frames_err_d;
        end
    end

    assign rx_byte    = rx_byte_q;
    assign rx_valid   = rx_valid_q;
    assign rx_sof     = rx_sof_q;
    assign rx_eof     = rx_eof_q;
    assign rx_err     = rx_err_q;
    assign frame_len  = frame_len_q;
    assign frames_ok  = frames_ok_q;
    assign frames_err = frames_err_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Scoreboard bench for mii_rx_deframer: expected bytes and end-of-frame
// records are queued as nibbles are driven and popped as the DUT emits them.
module tb_mii_rx_deframer;

    logic        clk = 1'b0;
    logic        SW0;
    logic        miiI_en;
    logic [3:0]  miiI_d;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_err;
    logic [10:0] frame_len;
    logic [15:0] frames_ok;
    logic [15:0] frames_err;

    mii_rx_deframer dut (
        .clk        (clk),
        .SW0        (SW0),
        .miiI_en    (miiI_en),
        .miiI_d     (miiI_d),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rx_sof     (rx_sof),
        .rx_eof     (rx_eof),
        .rx_err     (rx_err),
        .frame_len  (frame_len),
        .frames_ok  (frames_ok),
        .frames_err (frames_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          eof_seen = 0;
    logic [8:0]  byte_q[$];
    logic [11:0] eof_q[$];
    logic [8:0]  mon_b;
    logic [11:0] mon_e;
    logic        prev_valid = 1'b0;
    logic [7:0]  frame[$];
    int          exp_ok  = 0;
    int          exp_err = 0;

    // Output monitor: pops the scoreboard whenever the DUT produces something.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_checks++;
            if (byte_q.size() == 0) begin
                n_fail++;
                $display("FAIL byte_unexpected: got %h sof %b, expected none", rx_byte, rx_sof);
            end else begin
                mon_b = byte_q.pop_front();
                if ({rx_sof, rx_byte} !== mon_b) begin
                    n_fail++;
                    $display("FAIL byte: got sof %b byte %h, expected sof %b byte %h",
                             rx_sof, rx_byte, mon_b[8], mon_b[7:0]);
                end
            end
            n_checks++;
            if (prev_valid) begin
                n_fail++;
                $display("FAIL valid_spacing: got two consecutive rx_valid, expected gap");
            end
        end
        if (rx_eof) begin
            eof_seen++;
            n_checks++;
            if (eof_q.size() == 0) begin
                n_fail++;
                $display("FAIL eof_unexpected: got err %b len %0d, expected none", rx_err, frame_len);
            end else begin
                mon_e = eof_q.pop_front();
                if ({rx_err, frame_len, rx_valid} !== {mon_e, 1'b0}) begin
                    n_fail++;
                    $display("FAIL eof: got err %b len %0d valid %b, expected err %b len %0d valid 0",
                             rx_err, frame_len, rx_valid, mon_e[11], mon_e[10:0]);
                end
            end
        end
        prev_valid = rx_valid;
    end

    task automatic nib(input logic e, input logic [3:0] d);
        miiI_en = e;
        miiI_d  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic make_random(input int n);
        frame.delete();
        for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
    endtask

    // Drives a frame with an acceptable preamble and queues what must come out.
    task automatic send_frame(input int npre, input bit extra);
        int len;
        bit err;
        for (int i = 0; i < npre; i++) nib(1'b1, 4'h5);
        nib(1'b1, 4'hD);
        for (int i = 0; i < frame.size(); i++) begin
            byte_q.push_back({(i == 0), frame[i]});
            nib(1'b1, frame[i][3:0]);
            nib(1'b1, frame[i][7:4]);
        end
        if (extra) nib(1'b1, 4'hA);
        len = frame.size();
        err = extra || (len < 64) || (len > 1518);
        eof_q.push_back({err, 11'(len)});
        if (err) exp_err++;
        else exp_ok++;
        nib(1'b0, 4'h0);
    endtask

    task automatic test_reset();
        SW0 = 1'b0;
        miiI_en = 1'b0;
        miiI_d = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rx_byte, rx_valid, rx_sof, rx_eof, rx_err, frame_len, frames_ok, frames_err} !== 55'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got byte %h v%b s%b e%b r%b len %0d ok %0d err %0d, expected all 0",
                     rx_byte, rx_valid, rx_sof, rx_eof, rx_err, frame_len, frames_ok, frames_err);
        end
        SW0 = 1'b1;
        repeat (3) nib(1'b0, 4'h0);
    endtask

    task automatic test_valid_frame();
        make_random(64);
        send_frame(15, 1'b0);
        repeat (3) nib(1'b0, 4'h0);
        n_checks++;
        if (frames_ok !== 16'(exp_ok) || frames_err !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL valid_counters: got ok %0d err %0d, expected ok %0d err %0d",
                     frames_ok, frames_err, exp_ok, exp_err);
        end
    endtask

    task automatic test_runt();
        logic [7:0] hdr[14];
        hdr = '{8'h54, 8'hff, 8'h01, 8'h21, 8'h23, 8'h24,
                8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'h12, 8'h34};
        frame.delete();
        foreach (hdr[i]) frame.push_back(hdr[i]);
        for (int i = 0; i < 34; i++) frame.push_back(8'(i * 7 + 3));
        send_frame(15, 1'b0);
        repeat (3) nib(1'b0, 4'h0);
        n_checks++;
        if (frames_ok !== 16'(exp_ok) || frames_err !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL runt_counters: got ok %0d err %0d, expected ok %0d err %0d",
                     frames_ok, frames_err, exp_ok, exp_err);
        end
    endtask

    task automatic test_bad_preamble();
        int eofs0;
        eofs0 = eof_seen;
        for (int n = 4; n <= 6; n += 2) begin
            for (int i = 0; i < n; i++) nib(1'b1, 4'h5);
            nib(1'b1, 4'hD);
            for (int i = 0; i < 20; i++) nib(1'b1, 4'(i));
            nib(1'b0, 4'h0);
            exp_err++;
        end
        nib(1'b1, 4'h3);
        nib(1'b1, 4'h5);
        nib(1'b0, 4'h0);
        exp_err++;
        repeat (2) nib(1'b0, 4'h0);
        n_checks++;
        if (eof_seen !== eofs0 || frames_err !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL bad_preamble: got eofs %0d err %0d, expected eofs %0d err %0d",
                     eof_seen, frames_err, eofs0, exp_err);
        end
        make_random(64);
        send_frame(7, 1'b0);
        repeat (3) nib(1'b0, 4'h0);
        n_checks++;
        if (frames_ok !== 16'(exp_ok) || frames_err !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL min_preamble_counters: got ok %0d err %0d, expected ok %0d err %0d",
                     frames_ok, frames_err, exp_ok, exp_err);
        end
    endtask

    task automatic test_odd_nibble();
        make_random(64);
        send_frame(15, 1'b1);
        frame.delete();
        send_frame(15, 1'b0);
        repeat (3) nib(1'b0, 4'h0);
        n_checks++;
        if (frames_ok !== 16'(exp_ok) || frames_err !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL odd_counters: got ok %0d err %0d, expected ok %0d err %0d",
                     frames_ok, frames_err, exp_ok, exp_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 15; i++) nib(1'b1, 4'h5);
        nib(1'b1, 4'hD);
        for (int i = 0; i < 5; i++) begin
            byte_q.push_back({(i == 0), 8'h55});
            nib(1'b1, 4'h5);
            nib(1'b1, 4'h5);
        end
        @(negedge clk);
        #1;
        SW0 = 1'b0;
        #1;
        n_checks++;
        if ({rx_byte, rx_valid, rx_sof, rx_eof, rx_err, frame_len, frames_ok, frames_err} !== 55'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got byte %h v%b ok %0d err %0d, expected all 0",
                     rx_byte, rx_valid, frames_ok, frames_err);
        end
        nib(1'b1, 4'h5);
        nib(1'b1, 4'h5);
        SW0 = 1'b1;
        exp_ok = 0;
        exp_err = 0;
        for (int i = 0; i < 40; i++) nib(1'b1, (i % 3 == 0) ? 4'hD : 4'h5);
        nib(1'b0, 4'h0);
        n_checks++;
        if (frames_ok !== 16'd0 || frames_err !== 16'd0 || rx_eof !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_tail: got ok %0d err %0d eof %b, expected 0 0 0",
                     frames_ok, frames_err, rx_eof);
        end
        make_random(64);
        send_frame(15, 1'b0);
        repeat (3) nib(1'b0, 4'h0);
        n_checks++;
        if (frames_ok !== 16'd1 || frames_err !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_next: got ok %0d err %0d, expected ok 1 err 0",
                     frames_ok, frames_err);
        end
    endtask

    task automatic test_oversize();
        make_random(1519);
        send_frame(15, 1'b0);
        make_random(1518);
        send_frame(15, 1'b0);
        repeat (3) nib(1'b0, 4'h0);
        n_checks++;
        if (frames_ok !== 16'(exp_ok) || frames_err !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL oversize_counters: got ok %0d err %0d, expected ok %0d err %0d",
                     frames_ok, frames_err, exp_ok, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        int eofs0;
        eofs0 = eof_seen;
        make_random(64);
        send_frame(15, 1'b0);
        make_random(65);
        send_frame(8, 1'b0);
        repeat (3) nib(1'b0, 4'h0);
        n_checks++;
        if (eof_seen !== eofs0 + 2 || frames_ok !== 16'(exp_ok) || frames_err !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL back_to_back: got eofs %0d ok %0d err %0d, expected eofs %0d ok %0d err %0d",
                     eof_seen - eofs0, frames_ok, frames_err, 2, exp_ok, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_runt();
        test_bad_preamble();
        test_odd_nibble();
        test_reset_mid_frame();
        test_oversize();
        test_back_to_back();
        repeat (4) nib(1'b0, 4'h0);
        n_checks++;
        if (byte_q.size() != 0 || eof_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d bytes %0d eofs outstanding, expected 0 0",
                     byte_q.size(), eof_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
